// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BHT/BTB with 2-bit counters, EX-stage mispredict
//            redirect and debugger-visible branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        bp_clear,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);

  localparam int c_entries = 1 << IDX_W;
  localparam int c_tag_w   = 30 - IDX_W;

  logic [c_entries-1:0] r_valid;
  logic [c_tag_w-1:0]   r_tag    [c_entries];
  logic [1:0]           r_ctr    [c_entries];
  logic [31:0]          r_target [c_entries];
  logic [31:0]          r_br_cnt;
  logic [31:0]          r_mis_cnt;

  logic [IDX_W-1:0]   w_if_idx;
  logic [c_tag_w-1:0] w_if_tag;
  logic               w_if_hit;
  logic [IDX_W-1:0]   w_ex_idx;
  logic [c_tag_w-1:0] w_ex_tag;
  logic               w_ex_hit;
  logic               w_ex_tag_eq;
  logic               w_ex_br;
  logic               w_br_wrong;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Lookup reads only registered state, so same-cycle updates are not visible
  assign w_if_idx    = if_pc[IDX_W+1:2];
  assign w_if_tag    = if_pc[31:IDX_W+2];
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + 32'd4;

  assign w_ex_idx    = ex_pc[IDX_W+1:2];
  assign w_ex_tag    = ex_pc[31:IDX_W+2];
  assign w_ex_tag_eq = r_tag[w_ex_idx] == w_ex_tag;
  assign w_ex_hit    = r_valid[w_ex_idx] && w_ex_tag_eq;
  assign w_ex_br     = ex_valid && ex_is_br;

  assign w_br_wrong  = (ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target));
  assign mispredict  = ex_valid && (ex_is_br ? w_br_wrong : ex_pred_taken);
  assign redirect_pc = (ex_is_br && ex_taken) ? ex_target : ex_pc + 32'd4;

  assign br_cnt  = r_br_cnt;
  assign mis_cnt = r_mis_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < c_entries; i++) begin
        r_tag[i]    <= '0;
        r_ctr[i]    <= 2'b01;
        r_target[i] <= '0;
      end
    end else if (bp_clear) begin
      r_valid <= '0;
    end else if (w_ex_br) begin
      r_valid[w_ex_idx] <= 1'b1;
      r_tag[w_ex_idx]   <= w_ex_tag;
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= sat_step(r_ctr[w_ex_idx], ex_taken);
        if (ex_taken) r_target[w_ex_idx] <= ex_target;
      end else begin
        // A miss (including an alias) replaces the whole entry
        r_ctr[w_ex_idx]    <= ex_taken ? 2'b10 : 2'b01;
        r_target[w_ex_idx] <= ex_target;
      end
    end else if (ex_valid && ex_pred_taken && w_ex_tag_eq) begin
      r_valid[w_ex_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_ex_br)    r_br_cnt  <= r_br_cnt + 32'd1;
      if (mispredict) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed self-checking bench for branch_predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        bp_clear;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  int n_pass;
  int n_total;

  branch_predictor #(.IDX_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_br       (ex_is_br),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .bp_clear       (bp_clear),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_cnt         (br_cnt),
    .mis_cnt        (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic br, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_is_br = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_tk, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    chk({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic cnts(input string tag, input logic [31:0] eb, input logic [31:0] em);
    chk({tag, "_br_cnt"}, br_cnt, eb);
    chk({tag, "_mis_cnt"}, mis_cnt, em);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; bp_clear = 1'b0; if_pc = 32'h100;
    ex_set(0, 0, 0, 0, 0, 0, 0);
    #2;
    look("rst", 32'h100, 0, 32'h104);
    cnts("rst", 0, 0);
    chk("rst_mis", {31'd0, mispredict}, 32'd0);
    rst = 1'b0;
    tick();

    // First taken resolve: mispredict; same-cycle lookup still sees old entry
    ex_set(1, 1, 32'h100, 1, 32'h80, 0, 0);
    chk("first_mis", {31'd0, mispredict}, 32'd1);
    chk("first_redir", redirect_pc, 32'h80);
    look("same_cycle", 32'h100, 0, 32'h104);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("trained", 32'h100, 1, 32'h80);
    cnts("trained", 1, 1);

    // Three correctly predicted taken updates saturate the counter
    ex_set(1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
    chk("sat_nomis", {31'd0, mispredict}, 32'd0);
    tick(); tick(); tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    cnts("sat", 4, 1);

    // 11 -> 10 still taken
    ex_set(1, 1, 32'h100, 0, 32'h0, 1, 32'h80);
    chk("nt1_mis", {31'd0, mispredict}, 32'd1);
    chk("nt1_redir", redirect_pc, 32'h104);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("nt1", 32'h100, 1, 32'h80);
    cnts("nt1", 5, 2);

    // 10 -> 01 not taken
    ex_set(1, 1, 32'h100, 0, 32'h0, 1, 32'h80);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("nt2", 32'h100, 0, 32'h104);
    cnts("nt2", 6, 3);

    // Alias: 0x200 shares index 0 with 0x100
    ex_set(1, 1, 32'h100, 1, 32'h80, 0, 0);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("retrain", 32'h100, 1, 32'h80);
    look("alias_miss", 32'h200, 0, 32'h204);
    ex_set(1, 1, 32'h200, 0, 32'h300, 0, 0);
    chk("alias_nomis", {31'd0, mispredict}, 32'd0);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("alias_repl", 32'h100, 0, 32'h104);
    cnts("alias", 8, 4);
    ex_set(1, 1, 32'h200, 1, 32'h240, 0, 0);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("alias_own", 32'h200, 1, 32'h240);
    cnts("alias2", 9, 5);

    // Non-branch false hit invalidates the entry
    ex_set(1, 1, 32'h100, 1, 32'h80, 0, 0);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("nb_pre", 32'h100, 1, 32'h80);
    ex_set(1, 0, 32'h100, 0, 32'h0, 1, 32'h80);
    chk("nb_mis", {31'd0, mispredict}, 32'd1);
    chk("nb_redir", redirect_pc, 32'h104);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("nb_inval", 32'h100, 0, 32'h104);
    cnts("nb", 10, 7);
    ex_set(1, 0, 32'h100, 0, 32'h0, 0, 0);
    chk("nb_nopred", {31'd0, mispredict}, 32'd0);
    ex_set(0, 1, 32'h100, 1, 32'h80, 0, 0);
    chk("novalid", {31'd0, mispredict}, 32'd0);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    cnts("novalid", 10, 7);

    // bp_clear wins over a same-cycle update and clears other entries
    ex_set(1, 1, 32'h80, 1, 32'h10, 0, 0);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("pre_clr", 32'h80, 1, 32'h10);
    bp_clear = 1'b1;
    ex_set(1, 1, 32'h40, 1, 32'h500, 1, 32'h500);
    chk("clr_nomis", {31'd0, mispredict}, 32'd0);
    tick();
    bp_clear = 1'b0;
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("clr_40", 32'h40, 0, 32'h44);
    look("clr_80", 32'h80, 0, 32'h84);
    cnts("clr", 12, 8);

    // Wrap of pc+4, and target-only mispredict
    look("wrap_look", 32'hFFFF_FFFC, 0, 32'h0);
    ex_set(1, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8);
    chk("wrap_redir", redirect_pc, 32'h0);
    tick();
    ex_set(1, 1, 32'h80, 1, 32'h60, 1, 32'h70);
    chk("tgt_mis", {31'd0, mispredict}, 32'd1);
    chk("tgt_redir", redirect_pc, 32'h60);
    tick();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("tgt_new", 32'h80, 1, 32'h60);
    cnts("tgt", 13, 10);

    // Asynchronous reset mid-cycle with an update pending
    ex_set(1, 1, 32'h80, 1, 32'h90, 0, 0);
    rst = 1'b1;
    #1;
    cnts("arst", 0, 0);
    look("arst", 32'h80, 0, 32'h84);
    tick();
    rst = 1'b0;
    ex_set(0, 0, 0, 0, 0, 0, 0);
    look("arst_post", 32'h80, 0, 32'h84);
    look("arst_200", 32'h200, 0, 32'h204);
    cnts("arst_post", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch prediction unit. It consumes the resolved outcome that the execute-stage branch comparator produces (`br_taken` plus target) and turns it into a prediction for the fetch stage: a direct-mapped branch history/target table with 2-bit saturating counters. It sits between IF (lookup) and EX (resolve/update), and drives the mispredict redirect for the pipeline flush logic. It also exposes branch and mispredict counters for the external debugger.

## Interface
- `IDX_W`, 6, table index width; `2**IDX_W` entries; index = `pc[IDX_W+1:2]`, tag = `pc[31:IDX_W+2]`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_pc` in 32: fetch PC to look up.
- `pred_taken` out 1: prediction for `if_pc`.
- `pred_target` out 32: predicted next PC for `if_pc`.
- `ex_valid` in 1: an instruction is resolving in EX this cycle.
- `ex_is_br` in 1: the EX instruction is a conditional branch or jump.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_taken` in 1: resolved outcome (comparator `br_taken`).
- `ex_target` in 32: resolved taken target.
- `ex_pred_taken` in 1: prediction carried down the pipe with the instruction.
- `ex_pred_target` in 32: predicted target carried down the pipe.
- `bp_clear` in 1: synchronous invalidate of all entries (debugger/fence.i).
- `mispredict` out 1: redirect required this cycle.
- `redirect_pc` out 32: correct next PC when `mispredict` is high.
- `br_cnt` out 32: resolved branches since reset.
- `mis_cnt` out 32: mispredicts since reset.

## Operation
- Entry fields: valid, tag (`30-IDX_W` bits), 2-bit counter, 32-bit target.
- Lookup (combinational from table state): hit = valid & tag match.
  - `pred_taken = hit & ctr[1]`.
  - `pred_target = pred_taken ? target : if_pc+4`.
- Resolve (combinational):
  - branch: `mispredict = ex_valid & ex_is_br & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target))`.
  - non-branch: `mispredict = ex_valid & !ex_is_br & ex_pred_taken`, covering aliased false hits.
  - `redirect_pc = (ex_is_br & ex_taken) ? ex_target : ex_pc+4`. It is don't-care when `mispredict=0` but must still be driven deterministically.
- Update on the clock edge when `ex_valid & ex_is_br`, indexed and tagged by `ex_pc`:
  - miss: allocate with valid=1, tag, ctr = `ex_taken ? 2'b10 : 2'b01`, target = `ex_target`.
  - hit: ctr saturating-increments if taken, saturating-decrements if not (00 and 11 hold); target is written only when taken.
- Non-branch with `ex_pred_taken=1`: invalidate the entry at `ex_pc` if its tag matches.
- Counters:
  - `br_cnt` increments on `ex_valid & ex_is_br`.
  - `mis_cnt` increments on `mispredict`.
  - Both wrap modulo 2^32.
- `bp_clear`: all valid bits are cleared at the edge and take priority over a same-cycle update. Counters are unaffected.

## Timing
- `rst` asserted: all valid bits 0, all ctr 01, targets 0, `br_cnt`/`mis_cnt` 0.
  - Outputs then read `pred_taken=0`, `pred_target=if_pc+4`, `mispredict=0` (given `ex_valid=0`).
- Lookup latency: 0 cycles (combinational on `if_pc`). `mispredict`/`redirect_pc` also have 0-cycle latency.
- A table write is visible to lookup in the cycle after the edge. A same-cycle lookup of the same index returns pre-update contents.
- Reset asserted mid-update: the update is discarded; reset state wins immediately (asynchronous). Deassertion is sampled synchronously by the logic.
- Aliasing: a different tag at the same index replaces the entry on update (no associativity).
- `pc+4` wraps modulo 2^32 (0xFFFFFFFC → 0x00000000).

## Test plan
- Reset, `if_pc=0x100` → `pred_taken=0`, `pred_target=0x104`; `br_cnt=mis_cnt=0`.
- Resolve branch `ex_pc=0x100`, taken, `ex_target=0x80`, `ex_pred_taken=0` → `mispredict=1`, `redirect_pc=0x80`. Next cycle `if_pc=0x100` → `pred_taken=1`, `pred_target=0x80`; `br_cnt=1`, `mis_cnt=1`.
- Counter saturation at 0x100: three further taken updates (ctr stays 11), then not-taken → ctr 10, still predicts taken; second not-taken → 01, `pred_taken=0`.
- Alias, `IDX_W=6`: train 0x100 taken, then look up 0x200 (same index, different tag) → `pred_taken=0`. Update 0x200 not-taken → entry replaced, and 0x100 now predicts not taken.
- Non-branch at `ex_pc=0x100` with `ex_pred_taken=1` → `mispredict=1`, `redirect_pc=0x104`, entry invalidated; `br_cnt` unchanged.
- `bp_clear` in the same cycle as a taken update at 0x40 → next cycle 0x40 misses. `rst` pulsed mid-sequence → counters 0 and all lookups miss immediately.
